// File: rtl/rank_delta_chk.sv
// Rank-delta convergence checker: nibble-serial |new-old|, running max, per-iteration report.
// Optional macro RANK_DELTA_SUM_EN adds a saturating delta accumulator on sum_delta.
//
// state  | meaning
// IDLE   | ready for a rank pair
// SUB    | nibble-serial new + ~old + 1, LSB nibble first
// ABS    | negate the difference when a borrow occurred
// UPD    | fold delta into the running max (and sum)
// REPORT | present iteration results, restart running max
module rank_delta_chk #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   old_rank,
   input  logic [WIDTH-1:0]   new_rank,
   input  logic               in_last,
   input  logic [WIDTH-1:0]   threshold,
   output logic               out_valid,
   output logic               converged,
   output logic [WIDTH-1:0]   max_delta,
   output logic [7:0]         iter_count,
   output logic [WIDTH+7:0]   sum_delta
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = $clog2(NIB);

   typedef enum logic [2:0] {IDLE, SUB, ABS, UPD, REPORT} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  opa, opb, diff, run_max, max_q;
   logic              carry, last_q, conv_q, hs, report;
   logic [CW-1:0]     nib_cnt;
   logic [7:0]        cnt_q, cnt_inc;
   logic [4:0]        nib_sum;

   assign hs      = in_valid & in_ready;
   assign report  = (state == REPORT);
   assign nib_sum = {1'b0, opb[3:0]} + {1'b0, ~opa[3:0]} + {4'b0000, carry};
   assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = SUB;
         SUB:     if (nib_cnt == '0) state_nxt = ABS;
         ABS:     state_nxt = UPD;
         UPD:     state_nxt = last_q ? REPORT : IDLE;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa     <= '0;
         opb     <= '0;
         diff    <= '0;
         carry   <= 1'b0;
         last_q  <= 1'b0;
         nib_cnt <= '0;
         run_max <= '0;
         max_q   <= '0;
         conv_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  opa     <= old_rank;
                  opb     <= new_rank;
                  last_q  <= in_last;
                  carry   <= 1'b1;
                  nib_cnt <= CW'(NIB - 1);
               end
            end
            SUB: begin
               // operands shift down so the active nibble is always [3:0]
               opa     <= opa >> 4;
               opb     <= opb >> 4;
               diff    <= {nib_sum[3:0], diff[WIDTH-1:4]};
               carry   <= nib_sum[4];
               nib_cnt <= nib_cnt - CW'(1);
            end
            ABS: begin
               if (!carry) diff <= (~diff) + WIDTH'(1);
            end
            UPD: begin
               if (diff > run_max) run_max <= diff;
            end
            REPORT: begin
               max_q   <= run_max;
               conv_q  <= (run_max <= threshold);
               cnt_q   <= cnt_inc;
               run_max <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef RANK_DELTA_SUM_EN
   logic [WIDTH+7:0] acc, sum_q;
   logic [WIDTH+8:0] acc_add;

   assign acc_add = {1'b0, acc} + {9'b0, diff};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         sum_q <= '0;
      end else if (state == UPD) begin
         acc <= acc_add[WIDTH+8] ? '1 : acc_add[WIDTH+7:0];
      end else if (report) begin
         sum_q <= acc;
         acc   <= '0;
      end
   end

   assign sum_delta = report ? acc : sum_q;
`else
   assign sum_delta = '0;
`endif

   // results are live during REPORT and held from the registered copies afterwards
   assign in_ready   = (state == IDLE) & ~rst;
   assign out_valid  = report;
   assign converged  = report ? (run_max <= threshold) : conv_q;
   assign max_delta  = report ? run_max : max_q;
   assign iter_count = report ? cnt_inc : cnt_q;

endmodule

// File: tb/tb_rank_delta_chk.sv
// Randomized bench for rank_delta_chk against an arithmetic model of the iteration reports.
module tb_rank_delta_chk;

   localparam int W   = 16;
   localparam int NIB = W / 4;
   localparam longint SUM_MAX = (64'd1 << (W + 8)) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    old_rank, new_rank, threshold;
   logic            in_last;
   logic            out_valid, converged;
   logic [W-1:0]    max_delta;
   logic [7:0]      iter_count;
   logic [W+7:0]    sum_delta;

   int n_cmp = 0;
   int n_bad = 0;

   longint m_max, m_sum, m_cnt;

   rank_delta_chk #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .old_rank(old_rank), .new_rank(new_rank), .in_last(in_last),
      .threshold(threshold), .out_valid(out_valid), .converged(converged),
      .max_delta(max_delta), .iter_count(iter_count), .sum_delta(sum_delta)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_max = 0; m_sum = 0; m_cnt = 0;
   endtask

   task automatic check_zero_outs(input string tag);
      check_val({tag, "_rdy"}, in_ready, 0);
      check_val({tag, "_ov"}, out_valid, 0);
      check_val({tag, "_conv"}, converged, 0);
      check_val({tag, "_max"}, max_delta, 0);
      check_val({tag, "_cnt"}, iter_count, 0);
      check_val({tag, "_sum"}, sum_delta, 0);
   endtask

   // Offer one pair; while busy keep in_valid high with junk that must be ignored.
   task automatic send_pair(input logic [W-1:0] o, input logic [W-1:0] n, input logic last);
      int k, ov_k, exp_lat;
      longint d, e_max, e_sum, e_cnt;
      logic e_conv;
      k = 0;
      while (!in_ready && k < 50) begin @(negedge clk); k++; end
      check_val("ready_wait", in_ready, 1);
      old_rank = o; new_rank = n; in_last = last; in_valid = 1'b1;
      @(negedge clk);
      old_rank = W'($urandom); new_rank = W'($urandom); in_last = 1'b1;

      d = (n >= o) ? longint'(n) - longint'(o) : longint'(o) - longint'(n);
      if (d > m_max) m_max = d;
      m_sum = (m_sum + d > SUM_MAX) ? SUM_MAX : m_sum + d;
      e_max  = m_max;
      e_conv = (m_max <= longint'(threshold));
      e_cnt  = (m_cnt >= 255) ? 255 : m_cnt + 1;
`ifdef RANK_DELTA_SUM_EN
      e_sum = m_sum;
`else
      e_sum = 0;
`endif

      k = 1; ov_k = 0;
      while (!in_ready && k < 20) begin
         if (out_valid) begin
            ov_k = k;
            check_val("rep_max", max_delta, e_max);
            check_val("rep_conv", converged, e_conv);
            check_val("rep_cnt", iter_count, e_cnt);
            check_val("rep_sum", sum_delta, e_sum);
         end
         @(negedge clk);
         k++;
      end
      in_valid = 1'b0;
      exp_lat = last ? NIB + 4 : NIB + 3;
      check_val("ready_lat", k, exp_lat);
      check_val("ov_lat", ov_k, last ? NIB + 3 : 0);
      if (last) begin
         check_val("hold_max", max_delta, e_max);
         check_val("hold_conv", converged, e_conv);
         check_val("hold_cnt", iter_count, e_cnt);
         check_val("hold_ov", out_valid, 0);
         m_max = 0; m_sum = 0; m_cnt = e_cnt;
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero_outs(tag);
      rst = 1'b0;
      #1;
      check_val({tag, "_rdy_rel"}, in_ready, 1);
      model_clear();
   endtask

   initial begin
      int len, seen;
      logic [W-1:0] o, n;
      rst = 1'b1; in_valid = 1'b0; old_rank = '0; new_rank = '0; in_last = 1'b0;
      threshold = '0;
      model_clear();
      repeat (2) @(negedge clk);
      check_zero_outs("por");
      rst = 1'b0;
      #1;
      check_val("por_rdy_rel", in_ready, 1);

      threshold = 16'h0300;
      send_pair(16'h1000, 16'h1234, 1'b1);

      threshold = 16'h0FFF;
      send_pair(16'h8000, 16'h7000, 1'b0);
      send_pair(16'h0010, 16'h0050, 1'b1);

      threshold = 16'h0000;
      send_pair(16'hFFFF, 16'hFFFF, 1'b1);

      threshold = 16'hFFFE;
      send_pair(16'hFFFF, 16'h0000, 1'b1);
      threshold = 16'hFFFF;
      send_pair(16'h0000, 16'hFFFF, 1'b1);

      for (int it = 0; it < 40; it++) begin
         len = $urandom_range(1, 4);
         threshold = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 16'h0400)) : W'($urandom);
         for (int p = 0; p < len; p++) begin
            o = W'($urandom);
            n = ($urandom_range(0, 2) == 0) ? W'($urandom) : o + W'($urandom_range(0, 16'h0800)) - W'(16'h0400);
            send_pair(o, n, p == len - 1);
         end
      end

      // reset in SUB of a last pair: nothing reported, everything cleared
      while (!in_ready) @(negedge clk);
      old_rank = 16'h0001; new_rank = 16'h4000; in_last = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      do_reset("rst_sub");
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check_val("rst_sub_no_ov", seen, 0);
      check_val("rst_sub_max", max_delta, 0);
      check_val("rst_sub_cnt", iter_count, 0);

      for (int it = 0; it < 256; it++) begin
         threshold = W'($urandom);
         send_pair(W'($urandom), W'($urandom), 1'b1);
      end
      check_val("iter_sat", iter_count, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
